// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// alu_exec_ctrl_if : operand/result bus between the ALU initiator and the ALU
// Revision: 1.0
// ============================================================================
interface alu_exec_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cout;

  modport master (
    output alu_a, alu_b, alu_cin, alu_op,
    input  alu_out, alu_cout
  );

  modport slave (
    input  alu_a, alu_b, alu_cin, alu_op,
    output alu_out, alu_cout
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// alu_exec_ctrl : SAP-2 ALU initiator - accumulator, C/Z/S flags, 3-cycle sequencer
// Revision: 1.0
// ============================================================================
module alu_exec_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_cmp,
  input  logic             cmd_usec,
  input  logic [WIDTH-1:0] operand,
  input  logic             acc_ld,
  input  logic [WIDTH-1:0] acc_din,
  alu_exec_ctrl_if.master  alu,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_s,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_INC   = 4'h6;
  localparam logic [3:0] OP_DEC   = 4'h7;
  localparam logic [3:0] OP_RAL   = 4'h8;
  localparam logic [3:0] OP_RAR   = 4'h9;
  localparam logic [3:0] OP_PASSA = 4'hA;
  localparam logic [3:0] OP_PASSB = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             cmp_q, cmp_d;
  logic             cy_q, cy_d;
  logic             c_q, c_d, z_q, z_d, s_q, s_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] wb_acc;
  logic             wb_c, wb_z, wb_s, wb_ill;
  logic             acc_wr, zs_upd;
  logic             accept;

  // Writeback values derived from the captured result and the latched command
  always_comb begin
    wb_acc = acc_q;
    wb_c   = c_q;
    wb_z   = z_q;
    wb_s   = s_q;
    wb_ill = 1'b0;
    acc_wr = 1'b1;
    zs_upd = 1'b1;
    case (op_q)
      OP_ADD, OP_SUB:         wb_c = cy_q;
      OP_AND, OP_OR, OP_XOR:  wb_c = 1'b0;
      OP_INC, OP_DEC:         wb_c = c_q;
      OP_RAL, OP_RAR: begin
        wb_c   = cy_q;
        zs_upd = 1'b0;
      end
      OP_NOT, OP_PASSB:       zs_upd = 1'b0;
      OP_PASSA:               acc_wr = 1'b0;
      default: begin
        acc_wr = 1'b0;
        zs_upd = 1'b0;
        wb_ill = 1'b1;
      end
    endcase
    if (zs_upd) begin
      wb_z = (res_q == '0);
      wb_s = res_q[WIDTH-1];
    end
    if (acc_wr && !cmp_q) begin
      wb_acc = res_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    b_d       = b_q;
    res_d     = res_q;
    op_d      = op_q;
    cin_d     = cin_q;
    cmp_d     = cmp_q;
    cy_d      = cy_q;
    c_d       = c_q;
    z_d       = z_q;
    s_d       = s_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc_ld) begin
          acc_d = acc_din;
        end
        accept = start;
      end
      S_SETUP: state_d = S_EXEC;
      S_EXEC: begin
        res_d   = alu.alu_out;
        cy_d    = alu.alu_cout;
        state_d = S_WB;
      end
      default: begin
        acc_d     = wb_acc;
        c_d       = wb_c;
        z_d       = wb_z;
        s_d       = wb_s;
        done_d    = 1'b1;
        illegal_d = wb_ill;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
        // The done edge also accepts a new command so throughput is one per 3 cycles
        accept    = start;
      end
    endcase

    if (accept) begin
      op_d    = cmd_op;
      cmp_d   = cmd_cmp;
      b_d     = operand;
      busy_d  = 1'b1;
      state_d = S_SETUP;
      // c_d already reflects any writeback landing on this same edge
      case (cmd_op)
        OP_ADD, OP_SUB: cin_d = c_d & cmd_usec;
        OP_RAL, OP_RAR: cin_d = c_d;
        default:        cin_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      b_q       <= '0;
      res_q     <= '0;
      op_q      <= 4'h0;
      cin_q     <= 1'b0;
      cmp_q     <= 1'b0;
      cy_q      <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      s_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      res_q     <= res_d;
      op_q      <= op_d;
      cin_q     <= cin_d;
      cmp_q     <= cmp_d;
      cy_q      <= cy_d;
      c_q       <= c_d;
      z_q       <= z_d;
      s_q       <= s_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu.alu_a   = acc_q;
  assign alu.alu_b   = b_q;
  assign alu.alu_cin = cin_q;
  assign alu.alu_op  = op_q;

  assign acc     = acc_q;
  assign flag_c  = c_q;
  assign flag_z  = z_q;
  assign flag_s  = s_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_ctrl : bench for alu_exec_ctrl with a behavioural ALU and flag model
// Revision: 1.0
// ============================================================================
module tb_alu_exec_ctrl;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   cmd_op = 4'h0;
  logic         cmd_cmp = 1'b0;
  logic         cmd_usec = 1'b0;
  logic [W-1:0] operand = '0;
  logic         acc_ld = 1'b0;
  logic [W-1:0] acc_din = '0;
  logic [W-1:0] acc;
  logic         flag_c, flag_z, flag_s, busy, done, illegal;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_acc = '0;
  logic         m_c = 1'b0, m_z = 1'b0, m_s = 1'b0;

  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.WIDTH(W)) alu_bus ();

  alu_exec_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cmd_op   (cmd_op),
    .cmd_cmp  (cmd_cmp),
    .cmd_usec (cmd_usec),
    .operand  (operand),
    .acc_ld   (acc_ld),
    .acc_din  (acc_din),
    .alu      (alu_bus),
    .acc      (acc),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_s   (flag_s),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  // Combinational SAP-2 ALU standing in for the real one
  logic [W:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (alu_bus.alu_op)
      4'h0: alu_t = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b} + {{W{1'b0}}, alu_bus.alu_cin};
      4'h1: alu_t = {1'b0, alu_bus.alu_a} - {1'b0, alu_bus.alu_b} - {{W{1'b0}}, alu_bus.alu_cin};
      4'h2: alu_t = {1'b0, alu_bus.alu_a & alu_bus.alu_b};
      4'h3: alu_t = {1'b0, alu_bus.alu_a | alu_bus.alu_b};
      4'h4: alu_t = {1'b0, alu_bus.alu_a ^ alu_bus.alu_b};
      4'h5: alu_t = {1'b0, ~alu_bus.alu_a};
      4'h6: alu_t = {1'b0, alu_bus.alu_a} + 1'b1;
      4'h7: alu_t = {1'b0, alu_bus.alu_a} - 1'b1;
      4'h8: alu_t = {alu_bus.alu_a, alu_bus.alu_cin};
      4'h9: alu_t = {alu_bus.alu_a[0], alu_bus.alu_cin, alu_bus.alu_a[W-1:1]};
      4'hA: alu_t = {1'b0, alu_bus.alu_a};
      4'hB: alu_t = {1'b0, alu_bus.alu_b};
      default: alu_t = '0;
    endcase
  end
  assign alu_bus.alu_out  = alu_t[W-1:0];
  assign alu_bus.alu_cout = alu_t[W];

  // Architectural effect of one command, from the opcode rules in integer arithmetic
  function automatic void ref_cmd(input logic [3:0] op, input logic cmp, input logic usec,
                                  input logic [W-1:0] b, inout logic [W-1:0] a,
                                  inout logic c, inout logic z, inout logic s, output logic ill);
    int ai, bi, ci, r, rm;
    logic wr, zs;
    ai = int'(a); bi = int'(b); ci = c ? 1 : 0;
    ill = 1'b0; wr = 1'b1; zs = 1'b1; r = 0;
    case (op)
      4'h0: begin r = ai + bi + (usec ? ci : 0); c = (r >= MOD); end
      4'h1: begin r = ai - bi - (usec ? ci : 0); c = (r < 0); end
      4'h2: begin r = ai & bi; c = 1'b0; end
      4'h3: begin r = ai | bi; c = 1'b0; end
      4'h4: begin r = ai ^ bi; c = 1'b0; end
      4'h5: begin r = (MOD - 1) - ai; zs = 1'b0; end
      4'h6: r = ai + 1;
      4'h7: r = ai - 1;
      4'h8: begin r = ai * 2 + ci; c = (ai >= MOD / 2); zs = 1'b0; end
      4'h9: begin r = ai / 2 + ci * (MOD / 2); c = (ai % 2) == 1; zs = 1'b0; end
      4'hA: wr = 1'b0;
      4'hB: begin r = bi; zs = 1'b0; end
      default: begin ill = 1'b1; wr = 1'b0; zs = 1'b0; end
    endcase
    rm = ((r % MOD) + MOD) % MOD;
    if (op == 4'hA) rm = ai;
    if (zs) begin
      z = (rm == 0);
      s = (rm >= MOD / 2);
    end
    if (wr && !cmp) a = W'(rm);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command through the full start -> done window, checked against the model
  task automatic run_cmd(input logic [3:0] op, input logic cmp, input logic usec,
                         input logic ld, input logic [W-1:0] din, input logic [W-1:0] b);
    logic exp_cin, ill;
    if (ld) m_acc = din;
    if (op == 4'h8 || op == 4'h9) exp_cin = m_c;
    else if (op <= 4'h1)          exp_cin = m_c & usec;
    else                          exp_cin = 1'b0;
    cmd_op = op; cmd_cmp = cmp; cmd_usec = usec; operand = b;
    acc_ld = ld; acc_din = din; start = 1'b1;
    tick();
    start = 1'b0; acc_ld = 1'b0; acc_din = W'($urandom); operand = W'($urandom);
    cmd_op = 4'($urandom); cmd_usec = 1'($urandom);
    check($sformatf("op%0h_busy_k", op), busy, 1);
    check($sformatf("op%0h_alu_a", op), alu_bus.alu_a, m_acc);
    check($sformatf("op%0h_alu_b", op), alu_bus.alu_b, b);
    check($sformatf("op%0h_alu_op", op), alu_bus.alu_op, op);
    check($sformatf("op%0h_alu_cin", op), alu_bus.alu_cin, exp_cin);
    ref_cmd(op, cmp, usec, b, m_acc, m_c, m_z, m_s, ill);
    tick();
    check($sformatf("op%0h_early_done1", op), {busy, done}, 2'b10);
    tick();
    check($sformatf("op%0h_early_done2", op), {busy, done}, 2'b10);
    tick();
    check($sformatf("op%0h_done", op), {busy, done, illegal}, {2'b01, ill});
    check($sformatf("op%0h_acc", op), acc, m_acc);
    check($sformatf("op%0h_flags_czs", op), {flag_c, flag_z, flag_s}, {m_c, m_z, m_s});
    tick();
    check($sformatf("op%0h_done_clear", op), {done, illegal}, 2'b00);
  endtask

  typedef struct packed {
    logic [3:0]   op;
    logic         cmp, usec, ld;
    logic [W-1:0] din, b, e_acc;
    logic         e_c, e_z, e_s, e_ill;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{4'h0, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4'h1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4'h1, 1'b1, 1'b0, 1'b1, 8'h42, 8'h42, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'h1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'h8, 1'b0, 1'b0, 1'b1, 8'h80, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{4'hD, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{4'h6, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{4'h2, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'h3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h81, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'h5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'hB, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'hA, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{4'h9, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{4'h7, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{4'h0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{4'h4, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    check("reset_outputs", {acc, flag_c, flag_z, flag_s, busy, done, illegal}, '0);
    check("reset_alu_bus", {alu_bus.alu_b, alu_bus.alu_op, alu_bus.alu_cin}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors with hand-derived expectations
    for (int i = 0; i < 18; i++) begin
      run_cmd(tbl[i].op, tbl[i].cmp, tbl[i].usec, tbl[i].ld, tbl[i].din, tbl[i].b);
      check($sformatf("vec%0d_acc", i), acc, tbl[i].e_acc);
      check($sformatf("vec%0d_czs", i), {flag_c, flag_z, flag_s},
            {tbl[i].e_c, tbl[i].e_z, tbl[i].e_s});
      check($sformatf("vec%0d_illegal_seen", i), dut.illegal, 1'b0);
    end

    // Randomized commands against the reference model
    for (int n = 0; n < 150; n++) begin
      run_cmd(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'($urandom),
              ($urandom_range(0, 3) == 0), W'($urandom), W'($urandom));
    end

    // Idle load, then start held high for 10 cycles with acc_ld asserted while busy
    acc_ld = 1'b1; acc_din = 8'h10;
    tick();
    acc_ld = 1'b0;
    m_acc = 8'h10;
    check("idle_load", acc, 8'h10);
    cmd_op = 4'h6; cmd_cmp = 1'b0; cmd_usec = 1'b0; operand = 8'h00; acc_din = 8'h55;
    for (int i = 0; i < 16; i++) begin
      start  = (i < 10);
      acc_ld = (i >= 1 && i <= 11);
      tick();
      check($sformatf("b2b_done_c%0d", i), done, (i == 3 || i == 6 || i == 9 || i == 12));
      check($sformatf("b2b_busy_c%0d", i), busy, (i <= 11));
    end
    start = 1'b0; acc_ld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic ill;
      ref_cmd(4'h6, 1'b0, 1'b0, 8'h00, m_acc, m_c, m_z, m_s, ill);
    end
    check("b2b_acc", acc, m_acc);
    check("b2b_acc_value", acc, 8'h14);
    check("b2b_flags", {flag_c, flag_z, flag_s}, {m_c, m_z, m_s});

    // Reset during EXEC of an ADD aborts with no writeback
    cmd_op = 4'h0; operand = 8'h33; acc_ld = 1'b1; acc_din = 8'hAA; start = 1'b1;
    tick();
    start = 1'b0; acc_ld = 1'b0;
    check("rst_pre_acc", acc, 8'hAA);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {acc, flag_c, flag_z, flag_s, busy, done, illegal}, '0);
    check("rst_mid_alu_bus", {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_op, alu_bus.alu_cin}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rst_no_done_c%0d", i), {busy, done, illegal}, 3'b000);
    end
    check("rst_acc_after", acc, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Initiator side of the SAP-2 ALU interface. It owns the accumulator and the C/Z/S flag register, and drives the combinational ALU's A/B/cin/op inputs. It captures the ALU's out/cout and writes the accumulator and flags back under a per-opcode update policy. The control sequencer issues one command per start pulse and waits for a done pulse.

Parameters:
WIDTH, 8, data width of the accumulator, operand and ALU buses; flag logic uses bit WIDTH-1 as sign.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command request; sampled only in IDLE
cmd_op  input  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 INC, 7 DEC, 8 RAL, 9 RAR, A PASS A, B PASS B; C-F reserved
cmd_cmp  input  1  1 = flags only, accumulator not written
cmd_usec  input  1  ADD/SUB use flag_c as carry/borrow-in (ADC/SBB)
operand  input  WIDTH  B operand (from B/C/TMP register)
acc_ld  input  1  direct accumulator load (e.g. LDA/MVI A)
acc_din  input  WIDTH  data for acc_ld
alu_a  output  WIDTH  to ALU A (always equals acc)
alu_b  output  WIDTH  to ALU B (latched operand)
alu_cin  output  1  to ALU cin
alu_op  output  4  to ALU op (latched cmd_op)
alu_out  input  WIDTH  ALU result
alu_cout  input  1  ALU carry/borrow/rotate-out
acc  output  WIDTH  accumulator
flag_c, flag_z, flag_s  output  1 each  carry, zero, sign flags
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
illegal  output  1  one-cycle pulse with done when the command is reserved

Behaviour:
- Reset (async, rst_n=0): state IDLE; acc, alu_b, alu_op, alu_cin, all flags, busy, done and illegal are 0. Reset mid-command aborts it with no partial writeback.
- FSM: IDLE -> SETUP -> EXEC -> WB -> IDLE. SETUP, EXEC and WB each last exactly one cycle.
- Edge k, IDLE and start=1:
  - Latch cmd_op, cmd_cmp and operand into op_r, cmp_r and alu_b.
  - alu_cin = flag_c for RAL/RAR; flag_c & cmd_usec for ADD/SUB; 0 otherwise.
  - Go to SETUP; busy=1 from edge k.
- Edge k+1: SETUP -> EXEC. ALU inputs are held stable.
- Edge k+2: register alu_out into res_r and alu_cout into cy_r; go to WB.
- Edge k+3: apply writeback; assert done (and illegal if reserved) for exactly one cycle; busy=0; go to IDLE.
- Latency: start edge to done edge is 3 cycles. A start sampled high on the cycle done is high is accepted, giving back-to-back throughput of 1 command per 3 cycles.
- start while busy is ignored; no queuing.
- Writeback policy (Z = res==0, S = res[WIDTH-1]):
  - ADD/SUB: acc<=res; C<=cy; Z,S updated. SUB carry means borrow.
  - AND/OR/XOR: acc<=res; C<=0; Z,S updated.
  - NOT: acc<=res; flags unchanged.
  - INC/DEC: acc<=res; Z,S updated; C unchanged.
  - RAL/RAR: acc<=res; C<=cy; Z,S unchanged.
  - PASS A: acc unchanged; Z,S updated; C unchanged.
  - PASS B: acc<=res; flags unchanged.
  - Reserved C-F: no acc or flag change; done and illegal pulse.
- cmd_cmp=1 suppresses only the acc write; flags follow the table. CMP is SUB with cmp=1.
- acc_ld is honoured only in IDLE: acc<=acc_din, flags unchanged. acc_ld while busy is ignored.
- acc_ld and start in the same IDLE cycle: the load is applied at edge k, and the command uses the new acc value as A.
- alu_a = acc combinationally. acc cannot change while busy, so A is stable during SETUP and EXEC.
- All arithmetic wraps modulo 2^WIDTH; overflow is reported only through C.

Test Plan:
- Reset, acc_ld 0x7F, then ADD operand 0x01 -> done exactly 3 cycles after start; acc=0x80, S=1, Z=0, C=0; busy high for 3 cycles.
- acc=0x00, SUB operand 0x01 with cmd_usec=0 -> acc=0xFF, C=1, S=1. Then SUB 0x00 with cmd_usec=1 -> acc=0xFE, C=0.
- acc=0x42, CMP (op 1, cmp=1) operand 0x42 -> Z=1, C=0, acc stays 0x42. Next, RAL with C=1 and acc=0x80 -> acc=0x01, C=1, Z/S unchanged.
- start held high for 10 cycles -> commands accepted every 3rd cycle (on each done cycle); mid-command start pulses ignored; acc_ld during busy ignored.
- cmd_op=0xD -> done and illegal pulse together; acc and flags unchanged. INC on acc=0xFF with C=1 -> acc=0x00, Z=1, C stays 1.
- rst_n low during EXEC of ADD -> all outputs 0 immediately; after release, no done pulse appears.
